mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data bus width.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_req  input  1  SHALL be the instruction-fetch request, held high until i_ack.
REQ-006 i_addr  input  ADDR_W  SHALL be the fetch byte address.
REQ-007 i_rdata  output  DATA_W  SHALL be the fetched word, valid while i_ack is high.
REQ-008 i_ack  output  1  SHALL be a one-cycle fetch completion pulse.
REQ-009 d_req  input  1  SHALL be the data request, held high until d_ack.
REQ-010 d_we  input  4  SHALL be byte-lane write enables; bit3 is lane [31:24]; 4'b0000 means read.
REQ-011 d_addr, d_wdata  input  ADDR_W, DATA_W  SHALL be the data address and write data.
REQ-012 d_rdata, d_ack  output  DATA_W, 1  SHALL be the load data and a one-cycle completion pulse.
REQ-013 m_req, m_addr, m_we, m_wdata  output  1, ADDR_W, 4, DATA_W  SHALL drive the shared single-port memory.
REQ-014 m_rdata, m_ready  input  DATA_W, 1  SHALL be the memory read data and the completion strobe.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, BUS_I, BUS_D and RESP.
REQ-017 IDLE SHALL go to BUS_D or BUS_I per the arbitration rule when any request is high; otherwise it SHALL stay in IDLE.
REQ-018 On IDLE-to-BUS_x, the arbiter SHALL register the winner's address, write enables and write data.
REQ-019 m_addr SHALL be word-aligned: the registered address with bits [1:0] forced to 0.
REQ-020 In BUS_I, m_we SHALL be 4'b0000.
REQ-021 m_req SHALL be high exactly in BUS_I and BUS_D.
REQ-022 BUS_x SHALL hold until m_ready=1, then go to RESP and register m_rdata into x_rdata.
REQ-023 There SHALL be no cap on wait states.
REQ-024 In RESP, the granted requester's ack SHALL be high for exactly one cycle; RESP SHALL then go to IDLE.
REQ-025 Requests SHALL be ignored in RESP.
REQ-026 Minimum latency SHALL be 2 cycles: req in IDLE at cycle 0, m_ready in cycle 1, ack in cycle 2.
REQ-027 i_rdata and d_rdata SHALL hold their last value until the next completion of the same port.
REQ-028 d_rdata SHALL update on writes too, with m_rdata.
REQ-029 The arbiter SHALL NOT merge or reorder requests; each grant SHALL be exactly one memory transaction.
REQ-030 m_ready outside BUS_I and BUS_D SHALL be ignored.
REQ-031 Request lines dropping while in BUS_x SHALL NOT abort the transaction.

Reset
REQ-032 While rst=1 at a clock edge, state SHALL become IDLE, and m_req, i_ack, d_ack and busy SHALL be 0.
REQ-033 While rst=1 at a clock edge, i_rdata, d_rdata, the registered address, write data and write enables, and the round-robin pointer SHALL be 0.
REQ-034 Reset asserted in BUS_x or RESP SHALL abandon the transaction: m_req low and no ack from the next cycle.

Configuration
REQ-035 With ARB_RR_EN defined, simultaneous requests SHALL alternate using a 1-bit last-grant pointer, updated on each grant.
REQ-036 With ARB_RR_EN defined, the pointer SHALL reset to "last = I", so data wins first.
REQ-037 With ARB_RR_EN undefined, d_req SHALL always win over i_req, and no pointer register SHALL exist.

Structure
REQ-038 A shared package SHALL hold the state encoding (2 bits: IDLE=0, BUS_I=1, BUS_D=2, RESP=3).
REQ-039 The shared package SHALL hold the byte-lane width constant (4) and the DATA_W/ADDR_W defaults.
REQ-040 Arbitration (request pair plus pointer to grant) SHALL be one combinational sub-module, arb_pick.

Verification
REQ-041 Zero-wait fetch: i_req=1, i_addr=0x0000_0006, m_ready tied 1 -> m_addr=0x0000_0004 in cycle 1; i_ack and i_rdata=m_rdata in cycle 2.
REQ-042 Byte store: d_req=1, d_we=4'b0010, d_addr=0x10, d_wdata=0x0000_AB00, m_ready delayed 3 cycles -> m_req high 4 cycles, m_we=4'b0010, then one d_ack.
REQ-043 Contention, fixed priority: i_req and d_req both held high through three grants -> data granted every time.
REQ-044 Contention, ARB_RR_EN: i_req and d_req both held high through three grants -> grant order D, I, D.
REQ-045 Reset mid-transaction: rst=1 during BUS_D with m_ready=0 -> next cycle m_req=0, busy=0, no d_ack; after release, IDLE re-arbitrates.
REQ-046 Stray m_ready=1 in IDLE -> no ack and no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding, byte-lane count and bus-width defaults shared by the arbiter files
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS_I = 2'd1, BUS_D = 2'd2, RESP = 2'd3} state_t;
  localparam int LANES = 4;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: picks data vs fetch; last_d=1 means the previous grant went to data
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic grant_d
);
  assign grant_d = d_req & (~i_req | ~last_d);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports; ARB_RR_EN selects round-robin
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic [LANES-1:0]  d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LANES-1:0]  m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy
);
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [LANES-1:0] we_q;
  logic [DATA_W-1:0] wdata_q;
  logic gnt_d, pick_d, last_d, any;
  assign any = i_req | d_req;
  arb_pick u_pick (.i_req(i_req), .d_req(d_req), .last_d(last_d), .grant_d(pick_d));
`ifdef ARB_RR_EN
  // resets to "last = fetch" so data wins the first tie
  always_ff @(posedge clk)
    if (rst) last_d <= 1'b0;
    else if (state == IDLE && any) last_d <= pick_d;
`else
  assign last_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      we_q <= '0;
      wdata_q <= '0;
      gnt_d <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= next;
      if (state == IDLE && any) begin
        addr_q <= pick_d ? d_addr : i_addr;
        we_q <= pick_d ? d_we : '0;
        wdata_q <= pick_d ? d_wdata : '0;
        gnt_d <= pick_d;
      end
      if (state == BUS_I && m_ready) i_rdata <= m_rdata;
      if (state == BUS_D && m_ready) d_rdata <= m_rdata;
    end
  end
  always_comb begin
    next = state;
    m_req = state == BUS_I || state == BUS_D;
    m_addr = addr_q & {{(ADDR_W-2){1'b1}}, 2'b00};
    m_we = state == BUS_D ? we_q : '0;
    m_wdata = wdata_q;
    i_ack = state == RESP && !gnt_d;
    d_ack = state == RESP && gnt_d;
    busy = state != IDLE;
    if (state == IDLE) next = any ? (pick_d ? BUS_D : BUS_I) : IDLE;
    else if (state == RESP) next = IDLE;
    else if (m_ready) next = RESP;
  end
endmodule
